// File: rtl/serial_rx_fifo.sv
// ---------------------------------------------------------------------------
// serial_rx_fifo
//   8N1 UART receiver feeding a small first-word-fall-through receive FIFO.
//   The raw RX pin is synchronised, framed by a mid-bit sampling FSM and each
//   byte with a good stop bit is queued for software.
//
// Ports
//   clk        system clock
//   resetn     asynchronous active-low reset
//   serial_in  raw RX line (asynchronous, idle high)
//   rd         one-cycle pop strobe
//   clr        one-cycle strobe clearing overrun and frame_err
//   rd_data    FIFO head byte, 8'h00 while empty
//   rx_valid   FIFO not empty
//   rx_full    FIFO holds FIFO_DEPTH bytes
//   overrun    sticky: good byte dropped because the FIFO was full
//   frame_err  sticky: stop bit sampled low
// ---------------------------------------------------------------------------
module serial_rx_fifo #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       serial_in,
  input  logic       rd,
  input  logic       clr,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [15:0] HALF_RELOAD = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] BIT_RELOAD  = 16'(CLK_DIV - 1);
  localparam logic [AW:0] PTR_ONE     = {{AW{1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [1:0]  r_sync;
  logic [2:0]  r_state;
  logic [15:0] r_count;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_rd_data;
  logic        r_rx_valid;
  logic        r_rx_full;
  logic        r_overrun;
  logic        r_frame_err;

  logic        w_rxs;
  logic        w_tick;
  logic [2:0]  w_state_nxt;
  logic [15:0] w_count_nxt;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_push;
  logic        w_frame_evt;

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_wr_en;
  logic        w_ovr_evt;
  logic [AW:0] w_wr_ptr_nxt;
  logic [AW:0] w_rd_ptr_nxt;
  logic        w_empty_nxt;
  logic        w_full_nxt;
  logic [7:0]  w_head_nxt;

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_count == 16'd0);

  // Two-flop synchroniser for the asynchronous RX pin, idles high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], serial_in};
    end
  end

  // Framing FSM next-state: mid-bit sampling, LSB-first assembly.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_count_nxt = HALF_RELOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_tick) begin
          // A start bit that is high again at its centre is a glitch.
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_count_nxt = BIT_RELOAD;
            w_idx_nxt   = 3'd0;
          end
        end else begin
          w_count_nxt = r_count - 16'd1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_count_nxt = BIT_RELOAD;
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_count_nxt = r_count - 16'd1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_rxs) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_evt = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_count_nxt = r_count - 16'd1;
        end
      end
      S_BREAK: begin
        // Hold here until the line returns high so a held-low line
        // is not mistaken for a stream of zero bytes.
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BREAK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Framing FSM state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_count <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = rd && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_ovr_evt = w_push && w_full && !w_pop;

  // Next pointers and next head, so the status outputs can be registered.
  always_comb begin
    if (w_wr_en) begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    w_full_nxt  = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                  (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
    if (w_empty_nxt) begin
      w_head_nxt = 8'h00;
    end else if (w_wr_en && (w_rd_ptr_nxt[AW-1:0] == r_wr_ptr[AW-1:0])) begin
      // The byte being written this cycle becomes the head.
      w_head_nxt = r_shift;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
      end
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Registered head/status outputs and sticky error flags (set beats clr).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_rx_full   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rd_data  <= w_head_nxt;
      r_rx_valid <= !w_empty_nxt;
      r_rx_full  <= w_full_nxt;
      if (w_ovr_evt) begin
        r_overrun <= 1'b1;
      end else if (clr) begin
        r_overrun <= 1'b0;
      end
      if (w_frame_evt) begin
        r_frame_err <= 1'b1;
      end else if (clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rx_valid  = r_rx_valid;
  assign rx_full   = r_rx_full;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_serial_rx_fifo
//   Table of frames applied to serial_rx_fifo with a byte scoreboard, plus
//   hand-written sequences for break, glitch, overflow, simultaneous
//   push/pop on a full FIFO and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_serial_rx_fifo;

  localparam int D      = 16;
  localparam int DEPTH  = 8;
  // Cycles from driving the start bit low to rx_valid being observed high:
  // 2 sync flops + 1 idle detect + D/2 to mid start + 9 bit periods.
  localparam int PUSH_C = 3 + D / 2 + 9 * D;

  logic       clk = 1'b0;
  logic       resetn;
  logic       serial_in;
  logic       rd;
  logic       clr;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       rx_full;
  logic       overrun;
  logic       frame_err;

  int         n_vec  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic       m_ovr;
  logic       m_ferr;
  int         first_hi;

  typedef struct packed {
    logic [7:0] data;
    logic       stop_ok;
    logic [3:0] n_pop;
  } vec_t;

  vec_t tbl [6];

  serial_rx_fifo #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .serial_in (serial_in),
    .rd        (rd),
    .clr       (clr),
    .rd_data   (rd_data),
    .rx_valid  (rx_valid),
    .rx_full   (rx_full),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    chk({tag, ":rd_data"},   {24'd0, rd_data},   {24'd0, head});
    chk({tag, ":rx_valid"},  {31'd0, rx_valid},  {31'd0, (exp_q.size() != 0)});
    chk({tag, ":rx_full"},   {31'd0, rx_full},   {31'd0, (exp_q.size() == DEPTH)});
    chk({tag, ":overrun"},   {31'd0, overrun},   {31'd0, m_ovr});
    chk({tag, ":frame_err"}, {31'd0, frame_err}, {31'd0, m_ferr});
  endtask

  // Drive one 8N1 frame; optionally pulse rd on cycle rd_at of the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at);
    logic [9:0] fr;
    fr       = {stop, d, 1'b0};
    first_hi = -1;
    for (int c = 0; c < 10 * D; c++) begin
      if (first_hi < 0 && rx_valid === 1'b1) first_hi = c;
      if (c == rd_at) begin
        chk("same_cycle_pop:data", {24'd0, rd_data}, {24'd0, exp_q[0]});
        rd = 1'b1;
        void'(exp_q.pop_front());
      end else begin
        rd = 1'b0;
      end
      serial_in = fr[c / D];
      @(negedge clk);
    end
    rd = 1'b0;
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic do_rd(input string tag);
    logic [7:0] e;
    chk({tag, ":pop_valid"}, {31'd0, rx_valid}, {31'd0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ":pop_data"}, {24'd0, rd_data}, {24'd0, e});
    end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr    = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    logic empty0;
    logic [9:0] fr;

    tbl[0] = '{8'hA5, 1'b1, 4'd1};
    tbl[1] = '{8'h01, 1'b1, 4'd0};
    tbl[2] = '{8'h02, 1'b1, 4'd0};
    tbl[3] = '{8'h03, 1'b1, 4'd0};
    tbl[4] = '{8'h04, 1'b1, 4'd4};
    tbl[5] = '{8'h3C, 1'b0, 4'd0};

    resetn    = 1'b0;
    serial_in = 1'b1;
    rd        = 1'b0;
    clr       = 1'b0;
    m_ovr     = 1'b0;
    m_ferr    = 1'b0;
    repeat (3) @(negedge clk);
    chk_status("reset");
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // Table: single byte with exact push timing, four back-to-back bytes, bad stop bit.
    for (int i = 0; i < 6; i++) begin
      empty0 = (exp_q.size() == 0);
      send_frame(tbl[i].data, tbl[i].stop_ok, -1);
      if (empty0)
        chk($sformatf("v%0d:push_cycle", i), first_hi,
            tbl[i].stop_ok ? PUSH_C : -1);
      chk_status($sformatf("v%0d:after_frame", i));
      for (int k = 0; k < int'(tbl[i].n_pop); k++) do_rd($sformatf("v%0d:rd%0d", i, k));
      chk_status($sformatf("v%0d:after_pops", i));
    end

    // Line held low for 40 bit times after the bad stop bit, then recovery.
    repeat (40 * D) @(negedge clk);
    chk_status("break_hold");
    serial_in = 1'b1;
    repeat (D) @(negedge clk);
    send_frame(8'h55, 1'b1, -1);
    chk_status("after_break");
    do_rd("break_rd");
    pulse_clr();
    chk_status("clr_ferr");

    // Short low glitch on an idle line.
    serial_in = 1'b0;
    repeat (D / 4) @(negedge clk);
    serial_in = 1'b1;
    repeat (2 * D) @(negedge clk);
    chk_status("glitch");
    do_rd("rd_empty");
    chk_status("rd_empty_after");

    // Overflow: nine bytes into eight entries.
    for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b1, -1);
    chk_status("overflow");
    pulse_clr();
    chk_status("clr_ovr");

    // Full FIFO: rd lands in the same cycle as the push.
    send_frame(8'hAA, 1'b1, PUSH_C - 1);
    chk_status("full_rd_push");
    for (int k = 0; k < DEPTH; k++) do_rd($sformatf("drain%0d", k));
    chk_status("drained");

    // Reset during bit 4 with two bytes queued.
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    chk_status("two_queued");
    fr = {1'b1, 8'h5A, 1'b0};
    for (int c = 0; c < 5 * D + D / 2; c++) begin
      serial_in = fr[c / D];
      @(negedge clk);
    end
    resetn = 1'b0;
    exp_q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    repeat (2) @(negedge clk);
    chk_status("reset_mid");
    serial_in = 1'b1;
    resetn    = 1'b1;
    repeat (D) @(negedge clk);
    send_frame(8'hC3, 1'b1, -1);
    chk("post_reset:push_cycle", first_hi, PUSH_C);
    chk_status("post_reset");
    do_rd("post_reset_rd");
    chk_status("post_reset_empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
